hzu: RTL and testbench

Hazard/scoreboard unit in the decode stage: the issue-side counterpart of the forwarding unit. It stalls ID when a needed source cannot be forwarded. This covers two cases: a load-use dependency on the instruction in ID/EX, and a dependency on a register still owed by a long-latency unit (divider, uncached load). It keeps a per-register pending scoreboard and an outstanding-operation counter, set on issue and cleared on long-latency write-back.

---
 rtl/hzu.sv | 89 ++++++++
 tb/tb_hzu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hzu.sv
// Decode-stage hazard/scoreboard unit: stalls ID on load-use, long-latency RAW/WAW, or a full outstanding table.
// stall is combinational; pending bits, pendingCount and sbErr update on the rising clock edge.
module hzu #(
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issueValid,
  input  logic [RF_ADDR_WIDTH-1:0] issueRs1,
  input  logic [RF_ADDR_WIDTH-1:0] issueRs2,
  input  logic                     issueUseRs1,
  input  logic                     issueUseRs2,
  input  logic [RF_ADDR_WIDTH-1:0] issueRd,
  input  logic                     issueLongLat,
  input  logic                     flush,
  input  logic                     idexMemRead,
  input  logic [RF_ADDR_WIDTH-1:0] idexRd,
  input  logic                     wbValid,
  input  logic [RF_ADDR_WIDTH-1:0] wbRd,
  output logic                     stall,
  output logic [CW-1:0]            pendingCount,
  output logic                     sbErr
);

  localparam int NREG = 2 ** RF_ADDR_WIDTH;

  logic [NREG-1:0] r_pending;
  logic [CW-1:0]   r_count;
  logic            r_err;

  logic [NREG-1:0] w_wbMask;
  logic [NREG-1:0] w_pendEff;
  logic [NREG-1:0] w_pendNext;
  logic            w_hitRs1, w_hitRs2, w_hitRd;
  logic            w_loadUse, w_raw, w_waw, w_full;
  logic            w_acc, w_wbOk, w_wbErr;

  // A completion this cycle already hides its register from the stall logic.
  always_comb begin
    w_wbMask = '0;
    if (wbValid) w_wbMask[wbRd] = 1'b1;
  end

  assign w_pendEff = r_pending & ~w_wbMask;

  assign w_hitRs1 = (issueRs1 != '0) && w_pendEff[issueRs1];
  assign w_hitRs2 = (issueRs2 != '0) && w_pendEff[issueRs2];
  assign w_hitRd  = (issueRd  != '0) && w_pendEff[issueRd];

  assign w_loadUse = idexMemRead && (idexRd != '0) &&
                     ((issueUseRs1 && (idexRd == issueRs1)) ||
                      (issueUseRs2 && (idexRd == issueRs2)));
  assign w_raw     = (issueUseRs1 && w_hitRs1) || (issueUseRs2 && w_hitRs2);
  assign w_waw     = issueLongLat && w_hitRd;
  assign w_full    = issueLongLat && (r_count == CW'(MAX_OUTSTANDING)) && !wbValid;

  assign stall = issueValid && !flush && (w_loadUse || w_raw || w_waw || w_full);
  assign w_acc = issueValid && !flush && !stall && issueLongLat && (issueRd != '0);

  // Completions for registers that were never pending are protocol errors and are otherwise ignored.
  assign w_wbOk  = wbValid && (wbRd != '0) && r_pending[wbRd];
  assign w_wbErr = wbValid && (((wbRd != '0) && !r_pending[wbRd]) || (r_count == '0));

  always_comb begin
    w_pendNext = r_pending;
    if (w_wbOk) w_pendNext[wbRd] = 1'b0;
    if (w_acc)  w_pendNext[issueRd] = 1'b1;
    w_pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pendNext;
      if (w_acc && !w_wbOk)      r_count <= r_count + CW'(1);
      else if (!w_acc && w_wbOk) r_count <= r_count - CW'(1);
      if (w_wbErr) r_err <= 1'b1;
    end
  end

  assign pendingCount = r_count;
  assign sbErr        = r_err;

endmodule

// File: tb/tb_hzu.sv
// Directed vector bench for hzu: each record drives one cycle and checks stall, pendingCount, sbErr before the edge.
module tb_hzu;

  logic       clk = 1'b0;
  logic       rst;
  logic       issueValid, issueUseRs1, issueUseRs2, issueLongLat, flush;
  logic [4:0] issueRs1, issueRs2, issueRd, idexRd, wbRd;
  logic       idexMemRead, wbValid;
  logic       stall, sbErr;
  logic [2:0] pendingCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hzu #(.RF_ADDR_WIDTH(5), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueRs1(issueRs1), .issueRs2(issueRs2),
    .issueUseRs1(issueUseRs1), .issueUseRs2(issueUseRs2),
    .issueRd(issueRd), .issueLongLat(issueLongLat), .flush(flush),
    .idexMemRead(idexMemRead), .idexRd(idexRd),
    .wbValid(wbValid), .wbRd(wbRd),
    .stall(stall), .pendingCount(pendingCount), .sbErr(sbErr)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       ll;
    logic       fl;
    logic       mr;
    logic [4:0] idrd;
    logic       wv;
    logic [4:0] wrd;
    logic       e_stall;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input int r, iv, rs1, u1, rs2, u2, rd, ll, fl, mr, idrd, wv, wrd,
                              es, ec, ee);
    vec_t v;
    v.rst = 1'(r);   v.iv = 1'(iv);
    v.rs1 = 5'(rs1); v.u1 = 1'(u1);
    v.rs2 = 5'(rs2); v.u2 = 1'(u2);
    v.rd  = 5'(rd);  v.ll = 1'(ll); v.fl = 1'(fl);
    v.mr  = 1'(mr);  v.idrd = 5'(idrd);
    v.wv  = 1'(wv);  v.wrd = 5'(wrd);
    v.e_stall = 1'(es); v.e_cnt = 3'(ec); v.e_err = 1'(ee);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; issueValid = v.iv;
    issueRs1 = v.rs1; issueUseRs1 = v.u1;
    issueRs2 = v.rs2; issueUseRs2 = v.u2;
    issueRd = v.rd; issueLongLat = v.ll; flush = v.fl;
    idexMemRead = v.mr; idexRd = v.idrd;
    wbValid = v.wv; wbRd = v.wrd;
  endtask

  task automatic check(input string name, input int idx, input logic es, input logic [2:0] ec,
                       input logic ee);
    checks += 3;
    if (stall !== es) begin
      errors++;
      $display("FAIL %s[%0d] stall: got %b expected %b", name, idx, stall, es);
    end
    if (pendingCount !== ec) begin
      errors++;
      $display("FAIL %s[%0d] pendingCount: got %0d expected %0d", name, idx, pendingCount, ec);
    end
    if (sbErr !== ee) begin
      errors++;
      $display("FAIL %s[%0d] sbErr: got %b expected %b", name, idx, sbErr, ee);
    end
  endtask

  initial begin
    //           rst iv rs1 u1 rs2 u2 rd ll fl mr idrd wv wrd  stall cnt err
    // load-use on rs1 / rs2, bubble release, x0 exemption, unused source
    tv.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 8, 1, 0, 0, 0, 1, 8, 0, 0,  1, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 8, 0, 0, 0, 0, 1, 8, 0, 0,  0, 0, 0));
    // long-latency RAW on x7, released by same-cycle completion
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0));
    tv.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0));
    tv.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    // WAW on x9, then reissue to x9 during its completion: set wins
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,  1, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 9,  0, 1, 0));
    tv.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 1, 0));
    tv.push_back(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    // fill to MAX_OUTSTANDING, fifth op stalls until a completion
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0,  0, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0,  0, 2, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0,  0, 3, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,  1, 4, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0,  1, 4, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 1, 1,  0, 4, 0));
    tv.push_back(mk(0, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 4, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,  0, 4, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 3, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  0, 2, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,  0, 1, 0));
    tv.push_back(mk(0, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    // flush masks a load-use stall and suppresses the x3 set
    tv.push_back(mk(0, 1, 5, 1, 0, 0, 3, 1, 1, 1, 5, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    // long-latency op to x0 has no scoreboard effect
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    // spurious completion sets sticky sbErr without touching the count
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1));
    // reset overrides a same-cycle issue and completion
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(mk(0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 1, 10, 0, 1, 1));
    tv.push_back(mk(0, 1, 10, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1));

    // Initial reset held two cycles, then check the reset state.
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("reset", 0, 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check("vec", i, tv[i].e_stall, tv[i].e_cnt, tv[i].e_err);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
